// File: rtl/m_stage_mem_unit.sv
// Memory stage: consumes the E/M pipeline register, issues loads/stores on a
// ready/valid data-memory port, stalls E/M while an access is outstanding and
// produces a registered writeback bundle tagged with the ROB id.
module m_stage_mem_unit #(
  parameter int WORD_SIZE    = 32,
  parameter int ROB_ID_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [1:0]              instruction_type,
  input  logic [WORD_SIZE-1:0]    pc,
  input  logic [2:0]              funct3,
  input  logic [WORD_SIZE-1:0]    aluResult,
  input  logic [WORD_SIZE-1:0]    s2,
  input  logic [ROB_ID_WIDTH-1:0] rob_id,
  output logic                    stall,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [WORD_SIZE-1:0]    mem_req_addr,
  output logic [WORD_SIZE-1:0]    mem_req_wdata,
  output logic [3:0]              mem_req_be,
  input  logic                    mem_resp_valid,
  input  logic [WORD_SIZE-1:0]    mem_resp_rdata,
  output logic                    wb_valid,
  output logic [ROB_ID_WIDTH-1:0] wb_rob_id,
  output logic [WORD_SIZE-1:0]    wb_pc,
  output logic [WORD_SIZE-1:0]    wb_result,
  output logic                    wb_exception
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_next;

  logic                 is_load, is_store, mem_op;
  logic                 illegal, misaligned, bad;
  logic                 done, accept;
  logic [1:0]           lane_q;
  logic [7:0]           load_byte;
  logic [15:0]          load_half;
  logic [WORD_SIZE-1:0] load_data;
  logic [WORD_SIZE-1:0] result_next;

  // Decode the op class and flag illegal or misaligned memory accesses.
  always_comb begin
    is_load    = (instruction_type == 2'b01);
    is_store   = (instruction_type == 2'b10);
    mem_op     = valid & (is_load | is_store);
    illegal    = 1'b0;
    if (is_load)
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (is_store)
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
    misaligned = ((funct3[1:0] == 2'b01) & aluResult[0]) |
                 ((funct3[1:0] == 2'b10) & (aluResult[1:0] != 2'b00));
    bad        = mem_op & (illegal | misaligned);
  end

  // Next-state, request valid and single-cycle completion pulse.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    done          = 1'b0;
    accept        = 1'b0;
    if (reset) begin
      unique case (state)
        S_IDLE: begin
          if (mem_op && !bad) begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
              accept = 1'b1;
              if (is_store) done = 1'b1;
              else          state_next = S_WAIT;
            end
          end else if (valid) begin
            done = 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            done       = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    stall = reset & mem_op & !done;
  end

  // Request address and lane-formatted store data / byte enables.
  always_comb begin
    mem_req_we   = is_store;
    mem_req_addr = {aluResult[WORD_SIZE-1:2], 2'b00};
    unique case (funct3[1:0])
      2'b00: begin
        mem_req_wdata = {4{s2[7:0]}};
        mem_req_be    = 4'b0001 << aluResult[1:0];
      end
      2'b01: begin
        mem_req_wdata = {2{s2[15:0]}};
        mem_req_be    = aluResult[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        mem_req_wdata = s2;
        mem_req_be    = 4'b1111;
      end
    endcase
  end

  // Extract and extend the load value using the lane captured at acceptance.
  always_comb begin
    unique case (lane_q)
      2'b00:   load_byte = mem_resp_rdata[7:0];
      2'b01:   load_byte = mem_resp_rdata[15:8];
      2'b10:   load_byte = mem_resp_rdata[23:16];
      default: load_byte = mem_resp_rdata[31:24];
    endcase
    load_half = lane_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    unique case (funct3[1:0])
      2'b00:   load_data = {{24{~funct3[2] & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{~funct3[2] & load_half[15]}}, load_half};
      default: load_data = mem_resp_rdata;
    endcase
  end

  // Select the writeback value for the completing op.
  always_comb begin
    if (bad || is_store) result_next = '0;
    else if (is_load)    result_next = load_data;
    else                 result_next = aluResult;
  end

  // FSM state register and load lane capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      lane_q <= '0;
    end else begin
      state <= state_next;
      if (accept) lane_q <= aluResult[1:0];
    end
  end

  // Writeback register: valid pulses on completion, payload holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      wb_rob_id    <= '0;
      wb_pc        <= '0;
      wb_result    <= '0;
      wb_exception <= 1'b0;
    end else begin
      wb_valid <= done;
      if (done) begin
        wb_rob_id    <= rob_id;
        wb_pc        <= pc;
        wb_result    <= result_next;
        wb_exception <= bad;
      end
    end
  end

endmodule
